// File: rtl/subchannel_merger_pkg.sv
// subch_merge_pkg: shared types for the subchannel merger.
// FSM states, merge modes and width helpers.
package subch_merge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INDEP,
    GANGED,
    FLUSH
  } merge_state_e;

  typedef enum logic {
    MODE_INDEP,
    MODE_GANGED
  } merge_mode_e;

  localparam int DEF_NSC   = 2;
  localparam int DEF_DEPTH = 8;
  localparam int PTR_W     = $clog2(DEF_DEPTH);
  localparam int SRC_W     = $clog2(DEF_NSC);

  function automatic int min1(input int w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/subchannel_merger_if.sv
// subchannel_merger_if: per-subchannel input beats and the merged
// host-side output stream, with master (source/sink) and slave views.
interface subchannel_merger_if
  import subch_merge_pkg::*;
#(
  parameter int NSC  = DEF_NSC,
  parameter int SW   = 40,
  parameter int DW   = 80,
  parameter int SRCW = SRC_W
);

  logic [NSC*SW-1:0] subch_data_in;
  logic [NSC-1:0]    subch_valid_in;
  logic [NSC-1:0]    subch_ready_out;
  logic [DW-1:0]     data_out;
  logic              data_out_valid;
  logic              data_out_ready;
  logic [SRCW-1:0]   data_out_src;
  logic              data_out_parity;

  modport master (
    output subch_data_in,
    output subch_valid_in,
    output data_out_ready,
    input  subch_ready_out,
    input  data_out,
    input  data_out_valid,
    input  data_out_src,
    input  data_out_parity
  );

  modport slave (
    input  subch_data_in,
    input  subch_valid_in,
    input  data_out_ready,
    output subch_ready_out,
    output data_out,
    output data_out_valid,
    output data_out_src,
    output data_out_parity
  );

endinterface

// File: rtl/subchannel_merger_fifo.sv
// subch_sync_fifo: single-clock FIFO with push/pop/flush.
// Reads are from the head entry; no write-to-read bypass.
module subch_sync_fifo
  import subch_merge_pkg::*;
#(
  parameter int WIDTH = 40,
  parameter int DEPTH = 1 << PTR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // next pointers and occupancy; pointers wrap naturally
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
      if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end
  end

  // pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/subchannel_merger.sv
// subchannel_merger: merges per-subchannel read beats onto one host stream.
// Optional: define SUBCH_MERGE_PARITY_EN for registered even parity of data_out.
module subchannel_merger
  import subch_merge_pkg::*;
#(
  parameter int SUBCHANNEL_WIDTH = 40,
  parameter int NUM_SUBCHANNELS  = 2,
  parameter int DATA_WIDTH       = 80,
  parameter int FIFO_DEPTH       = 8,
  parameter int ALIGN_TIMEOUT    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_ganged,
  input  logic [NUM_SUBCHANNELS-1:0] cfg_subchannel_en,
  input  logic                       error_clr,
  output logic [min1($clog2(NUM_SUBCHANNELS))-1:0] arb_ptr,
  output logic                       error_status,
  subchannel_merger_if.slave         bus
);

  localparam int NSC  = NUM_SUBCHANNELS;
  localparam int SW   = SUBCHANNEL_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int SRCW = min1($clog2(NSC));
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int SKW  = $clog2(ALIGN_TIMEOUT + 1);

  merge_state_e    state_q, state_d;
  merge_mode_e     mode_q, mode_d;
  logic [SKW-1:0]  skew_q, skew_d;
  logic [SRCW-1:0] arb_q, arb_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic [SRCW-1:0] src_q, src_d;
  logic            vld_q, vld_d;
  logic            err_q, err_d;

  logic [NSC-1:0]  push, pop, full, empty;
  logic [SW-1:0]   fdata [NSC];
  logic [CW-1:0]   fcnt [NSC];
  logic            flush, run, drain_req, load_en;
  logic            fifos_empty, any_ne, all_ne;
  logic [SRCW-1:0] grant;
  logic            grant_vld;

  for (genvar i = 0; i < NSC; i++) begin : g_fifo
    subch_sync_fifo #(
      .WIDTH (SW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .flush_i (flush),
      .data_i  (bus.subch_data_in[i*SW +: SW]),
      .data_o  (fdata[i]),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .count_o (fcnt[i])
    );
  end

  assign run       = (state_q == INDEP) | (state_q == GANGED);
  assign drain_req = run & (merge_mode_e'(cfg_ganged) != mode_q);
  assign load_en   = ~vld_q | bus.data_out_ready;
  assign any_ne    = |(~empty);
  assign all_ne    = &(~empty);

  assign bus.subch_ready_out =
    cfg_subchannel_en & ~full & {NSC{run & ~drain_req}};
  assign push = bus.subch_valid_in & bus.subch_ready_out;

  // all FIFOs drained (used for mode switches)
  always_comb begin
    fifos_empty = 1'b1;
    for (int i = 0; i < NSC; i++) begin
      if (fcnt[i] != '0) fifos_empty = 1'b0;
    end
  end

  // round-robin pick, first non-empty after arb_ptr
  always_comb begin
    grant     = arb_q;
    grant_vld = 1'b0;
    for (int k = NSC; k >= 1; k--) begin
      if (!empty[(int'(arb_q) + k) % NSC]) begin
        grant     = SRCW'((int'(arb_q) + k) % NSC);
        grant_vld = 1'b1;
      end
    end
  end

  // next state, pops, output-register load and error tracking
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    skew_d  = skew_q;
    arb_d   = arb_q;
    dout_d  = dout_q;
    src_d   = src_q;
    vld_d   = vld_q & ~bus.data_out_ready;
    pop     = '0;
    flush   = 1'b0;
    err_d   = (err_q & ~error_clr) |
              (|(bus.subch_valid_in & ~cfg_subchannel_en));
    unique case (state_q)
      IDLE: begin
        skew_d = '0;
        if (fifos_empty && !vld_q) begin
          mode_d  = merge_mode_e'(cfg_ganged);
          state_d = cfg_ganged ? GANGED : INDEP;
        end
      end
      INDEP: begin
        if (load_en && grant_vld) begin
          pop[grant] = 1'b1;
          dout_d     = DW'(fdata[grant]);
          src_d      = grant;
          vld_d      = 1'b1;
          arb_d      = grant;
        end
        if (drain_req && fifos_empty && !vld_q) state_d = IDLE;
      end
      GANGED: begin
        if (load_en && all_ne) begin
          pop    = '1;
          dout_d = '0;
          for (int i = 0; i < NSC; i++) begin
            dout_d[i*SW +: SW] = fdata[i];
          end
          src_d  = '0;
          vld_d  = 1'b1;
          skew_d = '0;
        end else if (!any_ne) begin
          skew_d = '0;
        end else if (!all_ne) begin
          skew_d = skew_q + 1'b1;
        end
        if (!(&cfg_subchannel_en) ||
            (any_ne && !all_ne &&
             skew_q == SKW'(ALIGN_TIMEOUT - 1))) begin
          err_d   = 1'b1;
          state_d = FLUSH;
        end else if (drain_req && fifos_empty && !vld_q) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        flush   = 1'b1;
        skew_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, mode, arbitration, output word and error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_INDEP;
      skew_q  <= '0;
      arb_q   <= '0;
      dout_q  <= '0;
      src_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      skew_q  <= skew_d;
      arb_q   <= arb_d;
      dout_q  <= dout_d;
      src_q   <= src_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

`ifdef SUBCH_MERGE_PARITY_EN
  logic par_q;

  // parity follows the output word so it holds with it
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= ^dout_d;
  end

  assign bus.data_out_parity = par_q;
`else
  assign bus.data_out_parity = 1'b0;
`endif

  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = vld_q;
  assign bus.data_out_src   = src_q;
  assign arb_ptr            = arb_q;
  assign error_status       = err_q;

endmodule

// File: tb/tb_subchannel_merger.sv
// tb_subchannel_merger: directed bench for subchannel_merger with a
// queue-based scoreboard checking every accepted output word.
module tb_subchannel_merger;

  typedef struct packed {
    logic        g;
    logic [39:0] d;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_ganged;
  logic [1:0] cfg_en;
  logic       error_clr;
  logic [0:0] arb_ptr;
  logic       error_status;

  int total = 0;
  int bad   = 0;
  int out_cnt = 0;

  beat_t mq0[$];
  beat_t mq1[$];

  logic        hold = 1'b0;
  logic [79:0] h_data;
  logic [0:0]  h_src;

  subchannel_merger_if #(
    .NSC(2), .SW(40), .DW(80), .SRCW(1)
  ) bus ();

  subchannel_merger #(
    .SUBCHANNEL_WIDTH (40),
    .NUM_SUBCHANNELS  (2),
    .DATA_WIDTH       (80),
    .FIFO_DEPTH       (8),
    .ALIGN_TIMEOUT    (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_ganged        (cfg_ganged),
    .cfg_subchannel_en (cfg_en),
    .error_clr         (error_clr),
    .arb_ptr           (arb_ptr),
    .error_status      (error_status),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [79:0] act,
                     input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: ganged-tagged heads pair up, otherwise match by source
  task automatic score();
    beat_t b0, b1;
    out_cnt++;
    if (mq0.size() != 0 && mq0[0].g) begin
      chk("gang_pair", 80'(mq1.size() != 0), 80'd1);
      if (mq1.size() != 0) begin
        b0 = mq0.pop_front();
        b1 = mq1.pop_front();
        chk("gang_data", bus.data_out, {b1.d, b0.d});
        chk("gang_src", 80'(bus.data_out_src), 80'd0);
      end
    end else if (bus.data_out_src == 1'b0) begin
      chk("ind0_avail", 80'(mq0.size() != 0), 80'd1);
      if (mq0.size() != 0) begin
        b0 = mq0.pop_front();
        chk("ind0_mode", 80'(b0.g), 80'd0);
        chk("ind0_data", bus.data_out, {40'h0, b0.d});
      end
    end else begin
      chk("ind1_avail", 80'(mq1.size() != 0), 80'd1);
      if (mq1.size() != 0) begin
        b1 = mq1.pop_front();
        chk("ind1_mode", 80'(b1.g), 80'd0);
        chk("ind1_data", bus.data_out, {40'h0, b1.d});
      end
    end
  endtask

  // compare process, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      mq0.delete();
      mq1.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 80'(bus.data_out_valid), 80'd1);
        chk("hold_data", bus.data_out, h_data);
        chk("hold_src", 80'(bus.data_out_src), 80'(h_src));
      end
`ifdef SUBCH_MERGE_PARITY_EN
      if (bus.data_out_valid)
        chk("parity", 80'(bus.data_out_parity), 80'(^bus.data_out));
`else
      chk("parity", 80'(bus.data_out_parity), 80'd0);
`endif
      if (bus.data_out_valid && bus.data_out_ready) score();
      if (bus.subch_valid_in[0] && bus.subch_ready_out[0])
        mq0.push_back({cfg_ganged, bus.subch_data_in[39:0]});
      if (bus.subch_valid_in[1] && bus.subch_ready_out[1])
        mq1.push_back({cfg_ganged, bus.subch_data_in[79:40]});
      hold   = bus.data_out_valid & ~bus.data_out_ready;
      h_data = bus.data_out;
      h_src  = bus.data_out_src;
    end
  end

  task automatic wait_ready();
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus.subch_ready_out !== cfg_en && n < 40);
    chk("ready_wait", 80'(bus.subch_ready_out), 80'(cfg_en));
  endtask

  task automatic wait_drain();
    int n = 0;
    bus.data_out_ready = 1'b1;
    while ((mq0.size() + mq1.size() != 0 || bus.data_out_valid) &&
           n < 100) begin
      tick();
      n++;
    end
    chk("drain_done", 80'(n < 100), 80'd1);
  endtask

  task automatic push2(input logic [1:0] v,
                       input logic [39:0] d0,
                       input logic [39:0] d1);
    bus.subch_data_in  = {d1, d0};
    bus.subch_valid_in = v;
    tick();
    bus.subch_valid_in = 2'b00;
  endtask

  initial begin
    int n;
    int acc;
    int first_low;
    int oc0;
    rst                = 1'b1;
    cfg_ganged         = 1'b0;
    cfg_en             = 2'b11;
    error_clr          = 1'b0;
    bus.subch_data_in  = '0;
    bus.subch_valid_in = 2'b00;
    bus.data_out_ready = 1'b1;
    tick();
    tick();
    chk("rst_data", bus.data_out, 80'd0);
    chk("rst_valid", 80'(bus.data_out_valid), 80'd0);
    chk("rst_src", 80'(bus.data_out_src), 80'd0);
    chk("rst_arb", 80'(arb_ptr), 80'd0);
    chk("rst_err", 80'(error_status), 80'd0);
    chk("rst_ready", 80'(bus.subch_ready_out), 80'd0);
    rst = 1'b0;

    // independent round-robin
    wait_ready();
    push2(2'b11, 40'hA1, 40'hB2);
    chk("rr_latency", 80'(bus.data_out_valid), 80'd0);
    tick();
    chk("rr1_data", bus.data_out, 80'hB2);
    chk("rr1_src", 80'(bus.data_out_src), 80'd1);
    chk("rr1_arb", 80'(arb_ptr), 80'd1);
    tick();
    chk("rr2_data", bus.data_out, 80'hA1);
    chk("rr2_src", 80'(bus.data_out_src), 80'd0);
    chk("rr2_arb", 80'(arb_ptr), 80'd0);

    // ganged merge
    cfg_ganged = 1'b1;
    wait_ready();
    push2(2'b11, 40'h11_1111_1111, 40'h22_2222_2222);
    chk("gang_latency", 80'(bus.data_out_valid), 80'd0);
    tick();
    chk("gang_word", bus.data_out, 80'h2222222222_1111111111);
    chk("gang_vld", 80'(bus.data_out_valid), 80'd1);
    wait_drain();

    // backpressure and FIFO full
    cfg_ganged = 1'b0;
    wait_ready();
    bus.data_out_ready = 1'b0;
    acc = 0;
    first_low = -1;
    for (int k = 0; k < 12; k++) begin
      bus.subch_data_in  = {40'h0, 40'(k + 1)};
      bus.subch_valid_in = 2'b01;
      if (bus.subch_ready_out[0]) acc++;
      else if (first_low < 0) first_low = k;
      tick();
    end
    bus.subch_valid_in = 2'b00;
    chk("bp_accepted", 80'(acc), 80'd9);
    chk("bp_full_at", 80'(first_low), 80'd9);
    chk("bp_ready", 80'(bus.subch_ready_out[0]), 80'd0);
    chk("bp_head", bus.data_out, 80'd1);
    wait_drain();

    // ganged skew timeout
    cfg_ganged = 1'b1;
    wait_ready();
    bus.subch_data_in  = {40'h0, 40'h33};
    bus.subch_valid_in = 2'b01;
    n = 0;
    while (!error_status && n < 60) begin
      tick();
      n++;
    end
    bus.subch_valid_in = 2'b00;
    chk("skew_cycles", 80'(n), 80'd17);
    chk("skew_err", 80'(error_status), 80'd1);
    chk("flush_ready", 80'(bus.subch_ready_out), 80'd0);
    mq0.delete();
    mq1.delete();
    error_clr = 1'b1;
    tick();
    error_clr = 1'b0;
    chk("err_clr", 80'(error_status), 80'd0);
    wait_ready();
    push2(2'b11, 40'h44, 40'h55);
    tick();
    chk("post_flush", bus.data_out, {40'h55, 40'h44});
    wait_drain();

    // disabled-subchannel traffic
    cfg_ganged = 1'b0;
    wait_ready();
    cfg_en = 2'b01;
    push2(2'b10, 40'h0, 40'h5);
    chk("dis_err", 80'(error_status), 80'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("dis_noout", 80'(bus.data_out_valid), 80'd0);
    end
    error_clr = 1'b1;
    push2(2'b10, 40'h0, 40'h6);
    chk("set_dominant", 80'(error_status), 80'd1);
    tick();
    chk("clr_after", 80'(error_status), 80'd0);
    error_clr = 1'b0;
    cfg_en = 2'b11;

    // mode change mid-stream
    wait_ready();
    bus.data_out_ready = 1'b0;
    oc0 = out_cnt;
    for (int k = 0; k < 3; k++) begin
      push2(2'b11, 40'(16 + k), 40'(32 + k));
    end
    cfg_ganged = 1'b1;
    tick();
    chk("drain_ready", 80'(bus.subch_ready_out), 80'd0);
    bus.data_out_ready = 1'b1;
    wait_ready();
    chk("mode_words", 80'(out_cnt - oc0), 80'd6);
    chk("mode_lossless", 80'(mq0.size() + mq1.size()), 80'd0);
    push2(2'b11, 40'h66, 40'h67);
    wait_drain();

    // reset with data in flight
    bus.data_out_ready = 1'b0;
    push2(2'b11, 40'h70, 40'h71);
    push2(2'b11, 40'h72, 40'h73);
    tick();
    rst = 1'b1;
    tick();
    chk("rst2_data", bus.data_out, 80'd0);
    chk("rst2_valid", 80'(bus.data_out_valid), 80'd0);
    chk("rst2_src", 80'(bus.data_out_src), 80'd0);
    chk("rst2_par", 80'(bus.data_out_parity), 80'd0);
    chk("rst2_err", 80'(error_status), 80'd0);
    chk("rst2_ready", 80'(bus.subch_ready_out), 80'd0);
    rst = 1'b0;
    cfg_ganged = 1'b0;
    bus.data_out_ready = 1'b1;
    wait_ready();
    push2(2'b01, 40'h77, 40'h0);
    tick();
    chk("rst2_fresh", bus.data_out, 80'h77);
    chk("rst2_fsrc", 80'(bus.data_out_src), 80'd0);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/subchannel_merger.md
Name: subchannel_merger

Overview:
- Read-path counterpart of the write-side subchannel splitter in the DDR5 RCD data path.
- Accepts per-subchannel beats through valid/ready handshakes and buffers each subchannel in its own FIFO.
- Merges beats onto one wide host-side stream in one of two modes:
  - ganged: both halves concatenated into one word;
  - independent: round-robin arbitration, one beat per output word, tagged with its source.
- Detects and flags disabled-subchannel traffic and ganged-mode skew.

Parameters:
- SUBCHANNEL_WIDTH, 40, bits per subchannel beat.
- NUM_SUBCHANNELS, 2, number of subchannels; ganged mode requires exactly 2.
- DATA_WIDTH, 80, merged width; must equal NUM_SUBCHANNELS*SUBCHANNEL_WIDTH.
- FIFO_DEPTH, 8, entries per subchannel FIFO; power of two, >=2.
- ALIGN_TIMEOUT, 16, ganged skew limit in cycles; >=1.

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  synchronous, active-high reset.
- cfg_ganged  in  1  1 = ganged, 0 = independent; takes effect only in IDLE.
- cfg_subchannel_en  in  NUM_SUBCHANNELS  per-subchannel enable.
- subch_data_in  in  NUM_SUBCHANNELS*SUBCHANNEL_WIDTH  packed beats; subchannel i at [i*SW +: SW].
- subch_valid_in  in  NUM_SUBCHANNELS  beat valid.
- subch_ready_out  out  NUM_SUBCHANNELS  FIFO can accept.
- data_out  out  DATA_WIDTH  merged word.
- data_out_valid  out  1  output word valid.
- data_out_ready  in  1  downstream accept.
- data_out_src  out  $clog2(NUM_SUBCHANNELS)  source subchannel; 0 in ganged mode.
- data_out_parity  out  1  even parity of data_out (see Optional Feature).
- arb_ptr  out  $clog2(NUM_SUBCHANNELS)  last granted subchannel.
- error_status  out  1  sticky error flag.
- error_clr  in  1  clears error_status.

Behaviour:
- Reset:
  - All outputs are 0.
  - FIFOs are empty, skew counter is 0, state is IDLE, mode register is 0.
  - Reset mid-operation discards all buffered and in-flight beats.
- Input side:
  - Push occurs when subch_valid_in[i] & subch_ready_out[i].
  - subch_ready_out[i] = cfg_subchannel_en[i] & !full[i] & state in {INDEP, GANGED} & !drain_req.
  - subch_valid_in[i] while cfg_subchannel_en[i] = 0: beat dropped, error_status set.
- Output register:
  - Loads when !data_out_valid | data_out_ready; sustains 1 word/cycle.
  - data_out, data_out_src and data_out_parity hold stable while data_out_valid & !data_out_ready.
  - Latency: push at edge T gives data_out_valid high after edge T+1 (FIFOs and output register empty).
- FSM states: IDLE, INDEP, GANGED, FLUSH.
  - IDLE: ready low. When all FIFOs and the output register are empty, latch cfg_ganged into the mode register and go to GANGED or INDEP.
  - INDEP:
    - Round-robin grant among non-empty FIFOs, starting at arb_ptr+1 and wrapping modulo NUM_SUBCHANNELS.
    - arb_ptr <= granted subchannel.
    - data_out = zero-extended beat; data_out_src = grant.
    - A single requester is granted every cycle with no bubbles.
  - GANGED:
    - Pop both FIFOs only when both are non-empty.
    - data_out = {subch1, subch0}, with subch0 in the low half.
    - Skew counter increments each cycle exactly one FIFO is non-empty and no pop occurs; it clears on pop or when both FIFOs are empty.
    - Skew counter reaching ALIGN_TIMEOUT: set error, go to FLUSH.
    - Either enable deasserted in GANGED: set error, go to FLUSH.
  - FLUSH: one cycle. Empty all FIFOs; the output register still drains normally. Go to IDLE.
- Mode change:
  - cfg_ganged != mode register in INDEP/GANGED raises drain_req, forcing all readies low.
  - The FSM returns to IDLE once FIFOs and output are empty; no beat is lost.
- FIFO boundaries:
  - Full: ready low.
  - Empty: no pop.
  - Push and pop in the same cycle on a full FIFO is not possible (ready is low); on an empty FIFO the push is kept and no bypass occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- error_status:
  - Set-dominant over error_clr in the same cycle.
  - Cleared only by error_clr or rst.

Optional Feature:
- Macro SUBCH_MERGE_PARITY_EN.
- Defined: data_out_parity is ^data_out, registered with the output word and held with it under backpressure.
- Undefined: data_out_parity is tied to 0 and no parity logic is generated.

Decomposition:
- Shared package subch_merge_pkg:
  - merge_state_e (IDLE, INDEP, GANGED, FLUSH);
  - merge_mode_e (MODE_INDEP, MODE_GANGED);
  - localparams PTR_W and SRC_W derived via $clog2.
- One sub-module subch_sync_fifo:
  - parameterised width and depth;
  - push/pop/flush, full/empty, count;
  - instantiated once per subchannel via generate.

Test Plan:
- Independent round-robin: mode 0, both enabled, push 0xA1 on subch0 and 0xB2 on subch1 in the same cycle -> data_out 0x..B2 src 1, then 0x..A1 src 0 (arb_ptr starts at 0 so subch1 is granted first); arb_ptr ends at 0.
- Ganged merge: mode 1, push 0x11_1111_1111 on subch0 and 0x22_2222_2222 on subch1 -> data_out = 0x2222222222_1111111111 two edges after push, src 0.
- Backpressure/full: hold data_out_ready = 0 and push 9 beats on subch0 with FIFO_DEPTH = 8 -> output holds the first beat stable; the FIFO takes 8 more beats, i.e. 9 accepted in total (1 in the output register, 8 in the FIFO); subch_ready_out[0] falls after the 9th push; no loss after ready is released.
- Skew timeout: ganged mode, push only on subch0 for 16 cycles -> error_status high; FIFOs flushed; FSM passes through IDLE; error_clr pulse clears the flag.
- Disabled push: cfg_subchannel_en = 2'b01, subch_valid_in[1] = 1 with 0x5 -> beat dropped, error_status = 1, no output word.
- Mode change and reset: switch cfg_ganged mid-stream -> all queued words emitted before the new mode applies. Assert rst with data in flight -> next cycle all outputs are 0 and FIFOs are empty.
